// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_pkg                                                            |
// | Shared constants and types for the cache/main-memory arbiter slice.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cache_pkg;

  localparam int LINE_ADDR_LEN_DEF = 3;
  localparam int WORD_BYTES        = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t BURST = 2'd1;
  localparam state_t DONE  = 2'd2;

  typedef logic req_id_t;
  localparam req_id_t REQ_I = 1'b0;
  localparam req_id_t REQ_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_mem_arbiter_if                                                 |
// | Both cache line-request ports plus the word-serial memory port.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface cache_mem_arbiter_if #(
  parameter int LINE_ADDR_LEN = cache_pkg::LINE_ADDR_LEN_DEF,
  parameter int ADDR_W        = 32
);
  localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;

  logic                    i_req, i_we, i_done;
  logic [ADDR_W-1:0]       i_addr;
  logic [32*LINE_WORDS-1:0] i_wline, i_rline;
  logic                    d_req, d_we, d_done;
  logic [ADDR_W-1:0]       d_addr;
  logic [32*LINE_WORDS-1:0] d_wline, d_rline;
  logic                    mem_req, mem_we, mem_ready;
  logic [ADDR_W-1:0]       mem_addr;
  logic [31:0]             mem_wdata, mem_rdata;

  // Arbiter side.
  modport master (
    input  i_req, i_we, i_addr, i_wline, d_req, d_we, d_addr, d_wline,
           mem_rdata, mem_ready,
    output i_rline, i_done, d_rline, d_done,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  // Cache and memory side.
  modport slave (
    output i_req, i_we, i_addr, i_wline, d_req, d_we, d_addr, d_wline,
           mem_rdata, mem_ready,
    input  i_rline, i_done, d_rline, d_done,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2                                                          |
// | Combinational two-way round-robin picker; last_grant kept by parent. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter2
  import cache_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic       grant_valid,
  output req_id_t    grant_id
);
  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_I;
    if (req[REQ_D] && req[REQ_I]) begin
      grant_id = ~last_grant;
    end else if (req[REQ_D]) begin
      grant_id = REQ_D;
    end
  end
endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_mem_arbiter                                                    |
// | Round-robin I/D line-burst sequencer onto one word-serial memory.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int LINE_ADDR_LEN = cache_pkg::LINE_ADDR_LEN_DEF,
  parameter int ADDR_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_mem_arbiter_if.master bus,
  output logic [31:0]         i_served_cnt,
  output logic [31:0]         d_served_cnt
);
  localparam int                       LINE_WORDS = 1 << LINE_ADDR_LEN;
  localparam int                       WORD_SH    = $clog2(WORD_BYTES);
  localparam int                       OFF_BITS   = LINE_ADDR_LEN + WORD_SH;
  localparam logic [ADDR_W-1:0]        LINE_MASK  = ~ADDR_W'((1 << OFF_BITS) - 1);
  localparam logic [LINE_ADDR_LEN-1:0] LAST_BEAT  = LINE_ADDR_LEN'(LINE_WORDS - 1);

  state_t                    r_state, w_state_next;
  req_id_t                   r_owner, r_last_grant, w_gnt_id;
  logic                      r_we, w_gnt_valid;
  logic [ADDR_W-1:0]         r_line_addr;
  logic [LINE_ADDR_LEN-1:0]  r_beat;
  logic [32*LINE_WORDS-1:0]  r_buf, r_i_rline, r_d_rline;
  logic [31:0]               r_i_served_cnt, r_d_served_cnt;
  logic                      w_last_beat;

  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign i_served_cnt = r_i_served_cnt;
  assign d_served_cnt = r_d_served_cnt;

  rr_arbiter2 u_rr (
    .req         ({bus.d_req, bus.i_req}),
    .last_grant  (r_last_grant),
    .grant_valid (w_gnt_valid),
    .grant_id    (w_gnt_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_state_next = BURST;
      BURST:   if (bus.mem_ready && w_last_beat) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Requester inputs are only sampled at the grant edge; the latched copy drives the burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner        <= REQ_I;
      r_last_grant   <= REQ_I;
      r_we           <= 1'b0;
      r_line_addr    <= '0;
      r_beat         <= '0;
      r_buf          <= '0;
      r_i_rline      <= '0;
      r_d_rline      <= '0;
      r_i_served_cnt <= '0;
      r_d_served_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_valid) begin
          r_owner     <= w_gnt_id;
          r_we        <= (w_gnt_id == REQ_D) ? bus.d_we : bus.i_we;
          r_line_addr <= ((w_gnt_id == REQ_D) ? bus.d_addr : bus.i_addr) & LINE_MASK;
          r_buf       <= (w_gnt_id == REQ_D) ? bus.d_wline : bus.i_wline;
          r_beat      <= '0;
        end
        BURST: if (bus.mem_ready) begin
          if (!r_we) r_buf[{r_beat, 5'd0} +: 32] <= bus.mem_rdata;
          if (!w_last_beat) r_beat <= r_beat + 1'b1;
        end
        DONE: begin
          r_last_grant <= r_owner;
          if (r_owner == REQ_D) begin
            r_d_served_cnt <= r_d_served_cnt + 32'd1;
            r_d_rline      <= r_buf;
          end else begin
            r_i_served_cnt <= r_i_served_cnt + 32'd1;
            r_i_rline      <= r_buf;
          end
        end
        default: ;
      endcase
    end
  end

  // The owner's rline shows the live buffer during DONE and holds it afterwards.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    bus.i_rline   = r_i_rline;
    bus.d_rline   = r_d_rline;
    case (r_state)
      BURST: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = r_we;
        bus.mem_addr  = r_line_addr | (ADDR_W'(r_beat) << WORD_SH);
        bus.mem_wdata = r_buf[{r_beat, 5'd0} +: 32];
      end
      DONE: begin
        if (r_owner == REQ_D) begin
          bus.d_done  = 1'b1;
          bus.d_rline = r_buf;
        end else begin
          bus.i_done  = 1'b1;
          bus.i_rline = r_buf;
        end
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_mem_arbiter                                                 |
// | Randomized self-checking bench against a transaction-level model.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cache_mem_arbiter;
  import cache_pkg::*;

  localparam int LAL = 3;
  localparam int LW  = 8;
  localparam int AW  = 32;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_served_cnt, d_served_cnt;
  logic [31:0] rd_key = 32'h0;

  int checks = 0;
  int passes = 0;

  // Reference model: who was served last and how many lines each side got.
  req_id_t     m_last = REQ_I;
  logic [31:0] m_icnt = 32'h0;
  logic [31:0] m_dcnt = 32'h0;

  cache_mem_arbiter_if #(.LINE_ADDR_LEN(LAL), .ADDR_W(AW)) bus ();

  cache_mem_arbiter #(.LINE_ADDR_LEN(LAL), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .i_served_cnt (i_served_cnt),
    .d_served_cnt (d_served_cnt)
  );

  always #5 clk = ~clk;

  // Memory returns a scrambled copy of the beat address.
  assign bus.mem_rdata = bus.mem_addr ^ rd_key;

  beat_t mon_beats[$];
  int    beat_cyc[$];
  int    cyc = 0;
  int    last_beat_cyc = -10;
  logic  prev_stall = 1'b0;
  beat_t prev_b, mon_cur;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.mem_req) begin
        mon_cur = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
        if (prev_stall) begin
          checks++;
          if (mon_cur !== prev_b) $display("FAIL stall_hold: got %h required %h", mon_cur, prev_b);
          else passes++;
        end
        if (bus.mem_ready) begin
          mon_beats.push_back(mon_cur);
          beat_cyc.push_back(cyc);
          last_beat_cyc = cyc;
        end
        prev_stall = !bus.mem_ready;
        prev_b     = mon_cur;
      end else begin
        prev_stall = 1'b0;
      end
      if (bus.i_done || bus.d_done) begin
        checks++;
        if (cyc != last_beat_cyc + 1 || (bus.i_done && bus.d_done))
          $display("FAIL done_timing: done at cyc %0d last beat %0d i_done %b d_done %b",
                   cyc, last_beat_cyc, bus.i_done, bus.d_done);
        else passes++;
      end
    end
  end

  function automatic logic [255:0] refill_line(input logic [31:0] a, input logic [31:0] key);
    logic [255:0] r;
    for (int k = 0; k < LW; k++) r[32*k +: 32] = ((a & ~32'h1F) + 32'(4*k)) ^ key;
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < LW; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_idle();
    bus.i_req = 0; bus.i_we = 0; bus.i_addr = '0; bus.i_wline = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wline = '0;
    bus.mem_ready = 0;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_last = REQ_I; m_icnt = '0; m_dcnt = '0;
  endtask

  // Runs one or two line transactions to completion and checks them against the model.
  // mode: 0 = ready every cycle, 1 = ready every 3rd cycle, 2 = random ready.
  task automatic serve(input bit use_i, input bit use_d, input bit we_i, input bit we_d,
                       input logic [31:0] a_i, input logic [31:0] a_d,
                       input logic [255:0] wl_i, input logic [255:0] wl_d,
                       input int mode, input int drop_beat, output req_id_t first);
    req_id_t order[$];
    beat_t   exp[$];
    int      n = int'(use_i) + int'(use_d);
    int      ndone = 0;
    bit      dropped = 0;
    req_id_t o;
    logic [31:0]  line;
    logic [255:0] wl;
    bit      we;
    mon_beats.delete(); beat_cyc.delete();
    if (use_i && use_d) begin
      order.push_back((m_last == REQ_I) ? REQ_D : REQ_I);
      order.push_back(~order[0]);
    end else begin
      order.push_back(use_d ? REQ_D : REQ_I);
    end
    first = order[0];
    foreach (order[j]) begin
      line = ((order[j] == REQ_D) ? a_d : a_i) & ~32'h1F;
      wl   = (order[j] == REQ_D) ? wl_d : wl_i;
      we   = (order[j] == REQ_D) ? we_d : we_i;
      for (int k = 0; k < LW; k++) exp.push_back('{we, line + 32'(4*k), wl[32*k +: 32]});
    end
    bus.i_req = use_i; bus.i_we = we_i; bus.i_addr = a_i; bus.i_wline = wl_i;
    bus.d_req = use_d; bus.d_we = we_d; bus.d_addr = a_d; bus.d_wline = wl_d;
    for (int t = 0; t < 800 && ndone < n; t++) begin
      bus.mem_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 3 == 2) : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (t == 0) begin
        checks++;
        if (bus.mem_req !== 1'b1) $display("FAIL grant_latency: mem_req %b required 1", bus.mem_req);
        else passes++;
      end
      if (bus.i_done || bus.d_done) begin
        o  = bus.d_done ? REQ_D : REQ_I;
        we = (o == REQ_D) ? we_d : we_i;
        checks++;
        if (ndone >= n || o !== order[ndone])
          $display("FAIL grant_order: done #%0d from %0d", ndone, o);
        else passes++;
        if (!we) begin
          checks++;
          if (((o == REQ_D) ? bus.d_rline : bus.i_rline) !== refill_line((o == REQ_D) ? a_d : a_i, rd_key))
            $display("FAIL rline: got %h required %h", (o == REQ_D) ? bus.d_rline : bus.i_rline,
                     refill_line((o == REQ_D) ? a_d : a_i, rd_key));
          else passes++;
        end
        if (o == REQ_D) bus.d_req = 0; else bus.i_req = 0;
        ndone++;
      end
      if (drop_beat >= 0 && !dropped && mon_beats.size() == drop_beat) begin
        bus.d_req = 0; bus.d_addr = ~bus.d_addr; bus.d_we = ~bus.d_we; bus.d_wline = ~bus.d_wline;
        dropped = 1;
      end
    end
    bus.mem_ready = 0;
    bus.i_req = 0; bus.d_req = 0;
    @(posedge clk); #1;
    checks++;
    if (ndone != n) $display("FAIL done_count: got %0d required %0d", ndone, n);
    else passes++;
    checks++;
    if (mon_beats.size() != exp.size()) $display("FAIL beat_count: got %0d required %0d", mon_beats.size(), exp.size());
    else passes++;
    for (int k = 0; k < exp.size() && k < mon_beats.size(); k++) begin
      checks++;
      if (mon_beats[k] !== exp[k]) $display("FAIL beat[%0d]: got %h required %h", k, mon_beats[k], exp[k]);
      else passes++;
    end
    for (int j = 0; j < ndone && j < order.size(); j++) begin
      if (order[j] == REQ_D) m_dcnt++; else m_icnt++;
      m_last = order[j];
    end
    checks++;
    if (i_served_cnt !== m_icnt || d_served_cnt !== m_dcnt)
      $display("FAIL served_cnt: got i=%h d=%h required i=%h d=%h", i_served_cnt, d_served_cnt, m_icnt, m_dcnt);
    else passes++;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.i_done, bus.d_done} !== 4'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0)
      $display("FAIL reset_mem: req %b we %b addr %h wdata %h", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else passes++;
    checks++;
    if (bus.i_rline !== '0 || bus.d_rline !== '0 || i_served_cnt !== '0 || d_served_cnt !== '0)
      $display("FAIL reset_state: i_cnt %h d_cnt %h", i_served_cnt, d_served_cnt);
    else passes++;
    rst_n = 1'b1;
    m_last = REQ_I; m_icnt = '0; m_dcnt = '0;
  endtask

  task automatic test_single_d_refill();
    req_id_t f;
    rd_key = 32'h0;
    serve(0, 1, 0, 0, '0, 32'h0000_1234, '0, rand_line(), 0, -1, f);
    checks++;
    if (mon_beats.size() != LW || mon_beats[0].addr !== 32'h1220 || mon_beats[LW-1].addr !== 32'h123C ||
        beat_cyc[LW-1] != beat_cyc[0] + LW - 1)
      $display("FAIL d_refill_seq: %0d beats", mon_beats.size());
    else passes++;
    checks++;
    if (d_served_cnt !== 32'd1) $display("FAIL d_refill_cnt: got %h required 1", d_served_cnt);
    else passes++;
  endtask

  task automatic test_tie();
    req_id_t f;
    rd_key = 32'h5A5A_0000;
    for (int r = 0; r < 2; r++) begin
      serve(1, 1, 0, 0, 32'h0000_2000 + 32'(r * 64), 32'h0000_3000, '0, '0, 2, -1, f);
      checks++;
      if (f !== REQ_D) $display("FAIL tie_first[%0d]: got %0d required %0d", r, f, REQ_D);
      else passes++;
    end
  endtask

  task automatic test_writeback_stall();
    req_id_t f;
    logic [255:0] wl;
    for (int k = 0; k < LW; k++) wl[32*k +: 32] = 32'hA0 + 32'(k);
    serve(1, 0, 1, 0, 32'h40, '0, wl, '0, 1, -1, f);
  endtask

  task automatic test_drop_midburst();
    req_id_t f;
    rd_key = $urandom;
    serve(0, 1, 0, 0, '0, $urandom, '0, rand_line(), 2, 3, f);
  endtask

  task automatic test_async_reset();
    req_id_t f;
    int t;
    mon_beats.delete();
    bus.i_req = 1; bus.i_we = 0; bus.i_addr = 32'h0000_8800; bus.mem_ready = 1;
    for (t = 0; t < 50 && mon_beats.size() < 5; t++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (mon_beats.size() != 5) $display("FAIL reset_reach_beat5: got %0d beats", mon_beats.size());
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.i_done !== 1'b0 || i_served_cnt !== '0 || d_served_cnt !== '0)
      $display("FAIL async_reset: mem_req %b i_cnt %h d_cnt %h", bus.mem_req, i_served_cnt, d_served_cnt);
    else passes++;
    drive_idle();
    m_last = REQ_I; m_icnt = '0; m_dcnt = '0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rd_key = 32'h0F0F_0F0F;
    serve(1, 0, 0, 0, 32'h0000_9100, '0, '0, '0, 0, -1, f);
  endtask

  task automatic test_counter_wrap();
    req_id_t f;
    logic [31:0] i_before;
    i_before = i_served_cnt;
    force dut.r_d_served_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_d_served_cnt;
    m_dcnt = 32'hFFFF_FFFF;
    serve(0, 1, 1, 0, '0, 32'h0000_0480, '0, rand_line(), 0, -1, f);
    checks++;
    if (d_served_cnt !== 32'h0 || i_served_cnt !== i_before)
      $display("FAIL counter_wrap: d %h required 0, i %h required %h", d_served_cnt, i_served_cnt, i_before);
    else passes++;
  endtask

  task automatic test_random();
    req_id_t f;
    bit ui, ud;
    for (int r = 0; r < 12; r++) begin
      ui = 1'($urandom_range(0, 1));
      ud = ui ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_key = $urandom;
      serve(ui, ud, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
            rand_line(), rand_line(), $urandom_range(0, 2), -1, f);
    end
  endtask

  initial begin
    test_reset();
    test_single_d_refill();
    apply_reset();
    test_tie();
    test_writeback_stall();
    test_drop_midburst();
    test_async_reset();
    test_counter_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
